// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and default timing constants for the button event path
package btn_pkg;

    typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, LONG} btn_state_e;

    localparam int BTN_LONG_TICKS   = 1000;
    localparam int BTN_REPEAT_TICKS = 200;
    localparam int BTN_CNT_W        = 16;

endpackage

// File: rtl/btn_event_decoder_if.sv
// btn_event_decoder_if: debounced level in, single-cycle button events and held level out
interface btn_event_decoder_if;

    logic cleanbtn;
    logic press;
    logic release_evt;
    logic long_press;
    logic repeat_evt;
    logic held;

    modport master (input cleanbtn, output press, release_evt, long_press, repeat_evt, held);
    modport slave (output cleanbtn, input press, release_evt, long_press, repeat_evt, held);

endinterface

// File: rtl/btn_event_decoder_hold_timer.sv
// hold_timer: CNT_W up-counter with sync clear/enable; tc flags count == term-1
module hold_timer #(
    parameter int CNT_W = 16
) (
    input  logic             msclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge msclk)
        count <= (rst || clr) ? '0 : en ? count + CNT_W'(1) : count;

    assign tc = count == term - CNT_W'(1);

endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns the debounced button level into press/release/long/repeat pulses
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = BTN_LONG_TICKS,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS,
    parameter int CNT_W        = BTN_CNT_W
) (
    input logic                 msclk,
    input logic                 rst,
    btn_event_decoder_if.master bus
);

    if (LONG_TICKS < 1 || LONG_TICKS >= (1 << CNT_W) || REPEAT_TICKS < 0 || REPEAT_TICKS >= (1 << CNT_W)) begin : g_bad_params
        $error("btn_event_decoder: tick parameters out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LT     = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] RT     = CNT_W'(REPEAT_TICKS);
    localparam bit               RPT_EN = REPEAT_TICKS != 0;

    btn_state_e       state, state_n;
    logic             clr, en, tc;
    logic [CNT_W-1:0] count, term;
    logic             press_n, release_n, long_n, repeat_n;

    hold_timer #(.CNT_W(CNT_W)) u_timer (
        .msclk(msclk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .term (term),
        .count(count),
        .tc   (tc)
    );

    // release wins over long/repeat because it is tested first in each held state
    always_comb begin
        state_n   = state;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        term      = LT;
        case (state)
            LOCKOUT: begin
                clr = 1'b1;
                if (!bus.cleanbtn) state_n = IDLE;
            end
            IDLE: begin
                clr = 1'b1;
                if (bus.cleanbtn) begin
                    state_n = PRESSED;
                    press_n = 1'b1;
                end
            end
            PRESSED: begin
                en = 1'b1;
                if (!bus.cleanbtn) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else if (tc) begin
                    state_n = LONG;
                    long_n  = 1'b1;
                    clr     = 1'b1;
                end
            end
            LONG: begin
                term = RT;
                en   = RPT_EN;
                if (!bus.cleanbtn) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else if (RPT_EN && tc) begin
                    repeat_n = 1'b1;
                    clr      = 1'b1;
                end
            end
            default: state_n = LOCKOUT;
        endcase
    end

    always_ff @(posedge msclk) begin
        if (rst) begin
            state           <= LOCKOUT;
            bus.press       <= 1'b0;
            bus.release_evt <= 1'b0;
            bus.long_press  <= 1'b0;
            bus.repeat_evt  <= 1'b0;
            bus.held        <= 1'b0;
        end else begin
            state           <= state_n;
            bus.press       <= press_n;
            bus.release_evt <= release_n;
            bus.long_press  <= long_n;
            bus.repeat_evt  <= repeat_n;
            bus.held        <= state_n == PRESSED || state_n == LONG;
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed checks of the event decoder, with repeat enabled and disabled
module tb_btn_event_decoder;

    logic msclk = 1'b0;
    logic rst   = 1'b1;
    logic btn   = 1'b1;
    int   checks = 0, errors = 0;
    int   nlong = 0, nrpt = 0, nlong0 = 0, nrpt0 = 0;

    always #5 msclk = ~msclk;

    btn_event_decoder_if bus ();
    btn_event_decoder_if bus0 ();
    assign bus.cleanbtn  = btn;
    assign bus0.cleanbtn = btn;

    btn_event_decoder #(.LONG_TICKS(10), .REPEAT_TICKS(4), .CNT_W(8)) dut (
        .msclk(msclk),
        .rst  (rst),
        .bus  (bus)
    );

    btn_event_decoder #(.LONG_TICKS(10), .REPEAT_TICKS(0), .CNT_W(8)) dut0 (
        .msclk(msclk),
        .rst  (rst),
        .bus  (bus0)
    );

    // output vector order: {press, release, long_press, repeat, held}
    function automatic logic [4:0] hold_exp(input int i, input int rt);
        return {i == 0, 1'b0, i == 10, rt != 0 && i > 10 && (i - 10) % rt == 0, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_n(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic [4:0] e, input logic [4:0] e0, input string tag);
        btn = b;
        @(posedge msclk);
        #1;
        check(tag, {bus.press, bus.release_evt, bus.long_press, bus.repeat_evt, bus.held}, e);
        check({tag, "/r0"}, {bus0.press, bus0.release_evt, bus0.long_press, bus0.repeat_evt, bus0.held}, e0);
        nlong  += int'(bus.long_press);
        nrpt   += int'(bus.repeat_evt);
        nlong0 += int'(bus0.long_press);
        nrpt0  += int'(bus0.repeat_evt);
    endtask

    task automatic hold(input int n, input string tag);
        for (int i = 0; i < n; i++)
            cyc(1'b1, hold_exp(i, 4), hold_exp(i, 0), $sformatf("%s[%0d]", tag, i));
    endtask

    initial begin
        repeat (2) @(posedge msclk);
        #1;
        check("reset", {bus.press, bus.release_evt, bus.long_press, bus.repeat_evt, bus.held}, 5'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) cyc(1'b1, 5'b00000, 5'b00000, $sformatf("held_thru_reset[%0d]", i));
        cyc(1'b0, 5'b00000, 5'b00000, "lockout_exit");
        cyc(1'b1, 5'b10001, 5'b10001, "first_press");
        cyc(1'b0, 5'b01000, 5'b01000, "first_release");
        cyc(1'b0, 5'b00000, 5'b00000, "idle");

        hold(5, "short");
        cyc(1'b0, 5'b01000, 5'b01000, "short_release");
        cyc(1'b0, 5'b00000, 5'b00000, "short_idle");

        nlong = 0;
        nrpt  = 0;
        hold(30, "hold30");
        cyc(1'b0, 5'b01000, 5'b01000, "hold30_release");
        check_n("hold30_long_count", nlong, 1);
        check_n("hold30_repeat_count", nrpt, 4);
        cyc(1'b0, 5'b00000, 5'b00000, "hold30_idle");

        hold(10, "pre_long");
        cyc(1'b0, 5'b01000, 5'b01000, "release_beats_long");
        cyc(1'b0, 5'b00000, 5'b00000, "pre_long_idle");
        hold(14, "pre_repeat");
        cyc(1'b0, 5'b01000, 5'b01000, "release_beats_repeat");
        cyc(1'b0, 5'b00000, 5'b00000, "pre_repeat_idle");

        hold(3, "gap");
        cyc(1'b0, 5'b01000, 5'b01000, "gap_release");
        cyc(1'b1, 5'b10001, 5'b10001, "gap_press");
        cyc(1'b0, 5'b01000, 5'b01000, "gap_release2");
        cyc(1'b0, 5'b00000, 5'b00000, "gap_idle");

        hold(12, "rst_hold");
        rst = 1'b1;
        cyc(1'b1, 5'b00000, 5'b00000, "rst_mid_long");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc(1'b1, 5'b00000, 5'b00000, $sformatf("rst_lockout[%0d]", i));
        cyc(1'b0, 5'b00000, 5'b00000, "rst_lockout_exit");
        cyc(1'b1, 5'b10001, 5'b10001, "rst_repress");
        cyc(1'b0, 5'b01000, 5'b01000, "rst_rerelease");
        cyc(1'b0, 5'b00000, 5'b00000, "rst_idle");

        nlong  = 0;
        nrpt   = 0;
        nlong0 = 0;
        nrpt0  = 0;
        hold(40, "hold40");
        cyc(1'b0, 5'b01000, 5'b01000, "hold40_release");
        check_n("hold40_long_count", nlong, 1);
        check_n("hold40_repeat_count", nrpt, 7);
        check_n("hold40_r0_long_count", nlong0, 1);
        check_n("hold40_r0_repeat_count", nrpt0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
